// File: rtl/perceptron_trainer_if.sv
// Bundles the perceptron trainer's control, sample-memory and result signals.
// master = requester/sample-memory side, slave = trainer.
interface perceptron_trainer_if #(
    parameter int N_IN = 2,
    parameter int XW   = 7,
    parameter int WW   = 14,
    parameter int AW   = 4
);
    logic                   start;
    logic [AW-1:0]          num_samples;
    logic [AW-1:0]          smp_addr;
    logic [N_IN*XW+1:0]     smp_data;
    logic                   ready;
    logic                   converged;
    logic [N_IN*WW-1:0]     w;
    logic [WW-1:0]          bias;
    logic [7:0]             epoch_cnt;
    logic [AW:0]            err_cnt;

    modport master (
        output start, num_samples, smp_data,
        input  smp_addr, ready, converged, w, bias, epoch_cnt, err_cnt
    );

    modport slave (
        input  start, num_samples, smp_data,
        output smp_addr, ready, converged, w, bias, epoch_cnt, err_cnt
    );
endinterface

// File: rtl/perceptron_trainer.sv
// Perceptron trainer: streams samples from a synchronous memory, one MAC per cycle,
// applies saturating weight updates on misclassification until an error-free epoch or the epoch limit.
module perceptron_trainer #(
    parameter int N_IN      = 2,
    parameter int XW        = 7,
    parameter int WW        = 14,
    parameter int AW        = 4,
    parameter int LR_SHIFT  = 0,
    parameter int MAX_EPOCH = 255
) (
    input  logic                 clk,
    input  logic                 rst,
    perceptron_trainer_if.slave  bus
);
    localparam int ACCW = WW + XW + 4;
    localparam int SW   = WW + XW + LR_SHIFT + 2;
    localparam int SDW  = N_IN * XW + 2;
    localparam int IDXW = 4;
    localparam int EW   = AW + 1;

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_FETCH     = 3'd1;
    localparam logic [2:0] S_WAIT      = 3'd2;
    localparam logic [2:0] S_MAC       = 3'd3;
    localparam logic [2:0] S_DECIDE    = 3'd4;
    localparam logic [2:0] S_UPDATE    = 3'd5;
    localparam logic [2:0] S_EPOCH_END = 3'd6;
    localparam logic [2:0] S_DONE      = 3'd7;

    localparam logic signed [SW-1:0] W_MAX  = SW'((64'sd1 <<< (WW - 1)) - 64'sd1);
    localparam logic signed [SW-1:0] W_MIN  = ~W_MAX;
    localparam logic signed [SW-1:0] LR_ONE = SW'(64'sd1 <<< LR_SHIFT);

    logic [2:0]                 state_q, state_d;
    logic signed [WW-1:0]       w_q [N_IN];
    logic signed [WW-1:0]       w_d [N_IN];
    logic signed [WW-1:0]       bias_q, bias_d;
    logic signed [ACCW-1:0]     acc_q, acc_d;
    logic [SDW-1:0]             smp_q, smp_d;
    logic [IDXW-1:0]            idx_q, idx_d;
    logic [AW-1:0]              addr_q, addr_d;
    logic [7:0]                 epoch_q, epoch_d;
    logic [EW-1:0]              err_q, err_d;
    logic                       conv_q, conv_d;

    logic signed [WW-1:0]       w_sel;
    logic signed [XW-1:0]       x_sel;
    logic signed [ACCW-1:0]     prod;
    logic signed [SW-1:0]       xe  [N_IN];
    logic signed [SW-1:0]       dlt [N_IN];
    logic                       t_pos;
    logic                       mis;
    logic                       adv;
    logic [AW-1:0]              last_addr;
    logic [7:0]                 epoch_nx;
    logic [N_IN*WW-1:0]         w_pk;

    function automatic logic signed [WW-1:0] sat_add(input logic signed [WW-1:0] a,
                                                     input logic signed [SW-1:0] d);
        logic signed [SW-1:0] s;
        s = SW'(a) + d;
        if (s > W_MAX) begin
            sat_add = W_MAX[WW-1:0];
        end else if (s < W_MIN) begin
            sat_add = W_MIN[WW-1:0];
        end else begin
            sat_add = s[WW-1:0];
        end
    endfunction

    // Anything other than an exact +1 target counts as -1.
    assign t_pos     = (smp_q[SDW-1 -: 2] == 2'b01);
    assign mis       = (~acc_q[ACCW-1]) != t_pos;
    assign last_addr = bus.num_samples - AW'(1);
    assign epoch_nx  = epoch_q + 8'd1;

    always_comb begin
        w_sel = '0;
        x_sel = '0;
        for (int i = 0; i < N_IN; i++) begin
            if (idx_q == IDXW'(i)) begin
                w_sel = w_q[i];
                x_sel = smp_q[i*XW +: XW];
            end
        end
        prod = ACCW'(w_sel) * ACCW'(x_sel);
    end

    always_comb begin
        for (int i = 0; i < N_IN; i++) begin
            xe[i]  = SW'(signed'(smp_q[i*XW +: XW]));
            dlt[i] = (t_pos ? xe[i] : -xe[i]) <<< LR_SHIFT;
        end
    end

    always_comb begin
        state_d = state_q;
        w_d     = w_q;
        bias_d  = bias_q;
        acc_d   = acc_q;
        smp_d   = smp_q;
        idx_d   = idx_q;
        addr_d  = addr_q;
        epoch_d = epoch_q;
        err_d   = err_q;
        conv_d  = conv_q;
        adv     = 1'b0;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (bus.start) begin
                    for (int i = 0; i < N_IN; i++) begin
                        w_d[i] = '0;
                    end
                    bias_d  = '0;
                    epoch_d = '0;
                    err_d   = '0;
                    conv_d  = 1'b0;
                    addr_d  = '0;
                    state_d = S_FETCH;
                end
            end
            S_FETCH: begin
                state_d = S_WAIT;
            end
            S_WAIT: begin
                smp_d   = bus.smp_data;
                acc_d   = ACCW'(bias_q);
                idx_d   = '0;
                state_d = S_MAC;
            end
            S_MAC: begin
                acc_d = acc_q + prod;
                idx_d = idx_q + IDXW'(1);
                if (idx_q == IDXW'(N_IN - 1)) begin
                    state_d = S_DECIDE;
                end
            end
            S_DECIDE: begin
                if (mis) begin
                    err_d   = err_q + EW'(1);
                    state_d = S_UPDATE;
                end else begin
                    adv = 1'b1;
                end
            end
            S_UPDATE: begin
                for (int i = 0; i < N_IN; i++) begin
                    w_d[i] = sat_add(w_q[i], dlt[i]);
                end
                bias_d = sat_add(bias_q, t_pos ? LR_ONE : -LR_ONE);
                adv    = 1'b1;
            end
            S_EPOCH_END: begin
                epoch_d = epoch_nx;
                if (err_q == '0) begin
                    conv_d  = 1'b1;
                    state_d = S_DONE;
                end else if (epoch_nx >= 8'(MAX_EPOCH)) begin
                    conv_d  = 1'b0;
                    state_d = S_DONE;
                end else begin
                    err_d   = '0;
                    addr_d  = '0;
                    state_d = S_FETCH;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // num_samples==0 wraps last_addr to all-ones, giving a full 2^AW epoch.
        if (adv) begin
            if (addr_q == last_addr) begin
                addr_d  = '0;
                state_d = S_EPOCH_END;
            end else begin
                addr_d  = addr_q + AW'(1);
                state_d = S_FETCH;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            for (int i = 0; i < N_IN; i++) begin
                w_q[i] <= '0;
            end
            bias_q  <= '0;
            acc_q   <= '0;
            smp_q   <= '0;
            idx_q   <= '0;
            addr_q  <= '0;
            epoch_q <= '0;
            err_q   <= '0;
            conv_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            for (int i = 0; i < N_IN; i++) begin
                w_q[i] <= w_d[i];
            end
            bias_q  <= bias_d;
            acc_q   <= acc_d;
            smp_q   <= smp_d;
            idx_q   <= idx_d;
            addr_q  <= addr_d;
            epoch_q <= epoch_d;
            err_q   <= err_d;
            conv_q  <= conv_d;
        end
    end

    always_comb begin
        w_pk = '0;
        for (int i = 0; i < N_IN; i++) begin
            w_pk[i*WW +: WW] = w_q[i];
        end
    end

    assign bus.w         = w_pk;
    assign bus.bias      = bias_q;
    assign bus.smp_addr  = addr_q;
    assign bus.epoch_cnt = epoch_q;
    assign bus.err_cnt   = err_q;
    assign bus.converged = conv_q;
    assign bus.ready     = (state_q == S_IDLE) || (state_q == S_DONE);
endmodule
